move_input_ctrl: RTL and testbench

MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

---
 rtl/move_input_ctrl_pkg.sv | 33 +++
 rtl/move_input_ctrl_if.sv | 16 +
 rtl/move_input_ctrl_debounce.sv | 43 ++++
 rtl/move_input_ctrl_fsm.sv | 75 +++++++
 rtl/move_input_ctrl.sv | 83 ++++++++
 tb/tb_move_input_ctrl.sv | 181 ++++++++++++++++++
 6 files changed

// File: rtl/move_input_ctrl_pkg.sv
// rtl/move_input_ctrl_pkg.sv - shared frogger move constants
// Purpose: direction and move-FSM encodings shared by the move input slice,
//          plus a priority picker over the debounced direction levels.
// Ports:   none (package).
package move_input_ctrl_pkg;

  // Direction codes double as bit positions in the 4-bit level/pulse vectors.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } mv_state_t;

  // Up > Down > Left > Right; callers only use the result when some bit is set.
  function automatic dir_t pick_dir(input logic [3:0] lvl);
    if (lvl[DIR_UP])        return DIR_UP;
    else if (lvl[DIR_DOWN]) return DIR_DOWN;
    else if (lvl[DIR_LEFT]) return DIR_LEFT;
    else                    return DIR_RIGHT;
  endfunction

  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// rtl/move_input_ctrl_if.sv - debounced direction / move pulse bundle
// Purpose: carries debounced direction levels and the move enable into the
//          move FSM, and the registered move pulses back out.
// Signals: dir_lvl[3:0] debounced levels indexed by dir_t
//          move_en      game accepts moves
//          mvt[3:0]     single-cycle move pulses indexed by dir_t
interface move_input_ctrl_if;
  import move_input_ctrl_pkg::*;

  logic [3:0] dir_lvl;
  logic       move_en;
  logic [3:0] mvt;

  modport master (output dir_lvl, output move_en, input  mvt);
  modport slave  (input  dir_lvl, input  move_en, output mvt);
endinterface

// File: rtl/move_input_ctrl_debounce.sv
// rtl/move_input_ctrl_debounce.sv - 2-flop synchronizer plus debounce filter
// Purpose: synchronizes one raw button and only follows a new level after it
//          has been stable for c_DEBOUNCE_LIMIT cycles (c_DEBOUNCE_LIMIT >= 2).
// Ports:   i_Clk, i_Rst_L (async active-low), i_Raw raw button,
//          o_Level debounced level (registered).
module debounce_filter #(
  parameter int c_DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Level
);
  localparam int CW = $clog2(c_DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LP_LAST = CW'(c_DEBOUNCE_LIMIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_Raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LP_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_Level = r_level;
endmodule

// File: rtl/move_input_ctrl_fsm.sv
// rtl/move_input_ctrl_fsm.sv - move pulse FSM with hold-to-repeat
// Purpose: latches the highest-priority direction on a press, pulses once,
//          then auto-repeats after c_REPEAT_DELAY and every c_REPEAT_PERIOD
//          cycles while that direction stays held (c_REPEAT_PERIOD <= c_REPEAT_DELAY).
// Ports:   i_Clk, i_Rst_L (async active-low), bus (slave: dir_lvl, move_en in; mvt out).
module move_input_ctrl_fsm
  import move_input_ctrl_pkg::*;
#(
  parameter int c_REPEAT_DELAY  = 12500000,
  parameter int c_REPEAT_PERIOD = 5000000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  move_input_ctrl_if.slave   bus
);
  localparam int CW = $clog2(c_REPEAT_DELAY);
  localparam logic [CW-1:0] LP_DELAY_LAST  = CW'(c_REPEAT_DELAY - 1);
  localparam logic [CW-1:0] LP_PERIOD_LAST = CW'(c_REPEAT_PERIOD - 1);

  mv_state_t     r_state;
  dir_t          r_dir;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_mvt;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= ST_IDLE;
      r_dir   <= DIR_UP;
      r_cnt   <= '0;
      r_mvt   <= '0;
    end else begin
      r_mvt <= '0;
      if (!bus.move_en) begin
        // Disabling moves abandons any press in progress, including a due pulse.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (|bus.dir_lvl) begin
              r_dir   <= pick_dir(bus.dir_lvl);
              r_mvt   <= dir_onehot(pick_dir(bus.dir_lvl));
              r_cnt   <= '0;
              r_state <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (!bus.dir_lvl[r_dir]) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == LP_DELAY_LAST) begin
              r_mvt   <= dir_onehot(r_dir);
              r_cnt   <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          ST_REPEAT: begin
            if (!bus.dir_lvl[r_dir]) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == LP_PERIOD_LAST) begin
              r_mvt <= dir_onehot(r_dir);
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mvt = r_mvt;
endmodule

// File: rtl/move_input_ctrl.sv
// rtl/move_input_ctrl.sv - frog button input controller
// Purpose: debounces four direction buttons and start, produces single-cycle
//          move pulses with auto-repeat and a single-cycle game start pulse.
// Ports:   i_Clk, i_Rst_L (async active-low)
//          i_Up/Down/Left/Right_Btn, i_Start_Btn raw buttons (high = pressed)
//          i_Move_En  moves accepted
//          o_Up/Down/Left/Right_Mvt move pulses, o_Game_Start start pulse
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_REPEAT_DELAY   = 12500000,
  parameter int c_REPEAT_PERIOD  = 5000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Up_Btn,
  input  logic i_Down_Btn,
  input  logic i_Left_Btn,
  input  logic i_Right_Btn,
  input  logic i_Start_Btn,
  input  logic i_Move_En,
  output logic o_Up_Mvt,
  output logic o_Down_Mvt,
  output logic o_Left_Mvt,
  output logic o_Right_Mvt,
  output logic o_Game_Start
);
  logic [3:0] w_raw_dir;
  logic [3:0] w_dir_lvl;
  logic       w_start_lvl;
  logic       r_start_lvl_d;
  logic       r_game_start;

  move_input_ctrl_if u_bus ();

  assign w_raw_dir = {i_Right_Btn, i_Left_Btn, i_Down_Btn, i_Up_Btn};

  for (genvar g = 0; g < 4; g++) begin : g_dir_db
    debounce_filter #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_db (
      .i_Clk   (i_Clk),
      .i_Rst_L (i_Rst_L),
      .i_Raw   (w_raw_dir[g]),
      .o_Level (w_dir_lvl[g])
    );
  end

  debounce_filter #(.c_DEBOUNCE_LIMIT(c_DEBOUNCE_LIMIT)) u_start_db (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Raw   (i_Start_Btn),
    .o_Level (w_start_lvl)
  );

  assign u_bus.dir_lvl = w_dir_lvl;
  assign u_bus.move_en = i_Move_En;

  move_input_ctrl_fsm #(
    .c_REPEAT_DELAY  (c_REPEAT_DELAY),
    .c_REPEAT_PERIOD (c_REPEAT_PERIOD)
  ) u_fsm (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .bus     (u_bus)
  );

  // Start is edge-detected on the debounced level, independent of move_en.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_start_lvl_d <= 1'b0;
      r_game_start  <= 1'b0;
    end else begin
      r_start_lvl_d <= w_start_lvl;
      r_game_start  <= w_start_lvl & ~r_start_lvl_d;
    end
  end

  assign o_Up_Mvt     = u_bus.mvt[DIR_UP];
  assign o_Down_Mvt   = u_bus.mvt[DIR_DOWN];
  assign o_Left_Mvt   = u_bus.mvt[DIR_LEFT];
  assign o_Right_Mvt  = u_bus.mvt[DIR_RIGHT];
  assign o_Game_Start = r_game_start;
endmodule

// File: tb/tb_move_input_ctrl.sv
// tb/tb_move_input_ctrl.sv - scoreboard bench for move_input_ctrl
module tb_move_input_ctrl;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;
  localparam int ID_START = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic up, down, left, right, start;
  logic o_up, o_down, o_left, o_right, o_start;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n;

  typedef struct {
    int cyc;
    int id;
  } exp_t;
  exp_t sb[$];

  move_input_ctrl_if tb_if ();

  assign tb_if.mvt     = {o_right, o_left, o_down, o_up};
  assign tb_if.dir_lvl = {right, left, down, up};

  move_input_ctrl #(
    .c_DEBOUNCE_LIMIT (DB),
    .c_REPEAT_DELAY   (RD),
    .c_REPEAT_PERIOD  (RP)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Up_Btn     (up),
    .i_Down_Btn   (down),
    .i_Left_Btn   (left),
    .i_Right_Btn  (right),
    .i_Start_Btn  (start),
    .i_Move_En    (tb_if.move_en),
    .o_Up_Mvt     (o_up),
    .o_Down_Mvt   (o_down),
    .o_Left_Mvt   (o_left),
    .o_Right_Mvt  (o_right),
    .o_Game_Start (o_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input int id);
    exp_t e;
    e.cyc = c;
    e.id  = id;
    sb.push_back(e);
  endfunction

  // Drive point: just after the falling edge, so cyc equals the last rising edge.
  task automatic step(input int k);
    repeat (k) @(negedge clk);
    #2;
  endtask

  // Every pulse seen must match the head of the scoreboard in id and cycle;
  // a stretched or extra pulse therefore shows up as a mismatch.
  always @(negedge clk) begin
    logic [4:0] p;
    exp_t e;
    p = {o_start, tb_if.mvt};
    if (rst_n && p != 5'd0) begin
      if (tb_if.mvt != 4'd0) check("mvt_onehot", $countones(tb_if.mvt), 1);
      for (int i = 0; i < 5; i++) begin
        if (p[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", i, -1);
          end else begin
            e = sb.pop_front();
            check("pulse_id", i, e.id);
            check("pulse_cyc", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    {up, down, left, right, start} = 5'd0;
    tb_if.move_en = 1'b1;
    rst_n = 1'b0;
    step(3);
    check("reset_outputs", int'({o_start, tb_if.mvt}), 0);
    rst_n = 1'b1;
    step(2);

    // Up held 30 cycles: first pulse after debounce, then delay, then period.
    n = cyc;
    push(n + 7, 0); push(n + 17, 0); push(n + 22, 0); push(n + 27, 0); push(n + 32, 0);
    up = 1'b1;
    step(30);
    up = 1'b0;
    step(15);

    // Short Left glitch is filtered, a full-length press is not.
    left = 1'b1;
    step(DB - 1);
    left = 1'b0;
    step(10);
    n = cyc;
    push(n + 7, 2);
    left = 1'b1;
    step(DB);
    left = 1'b0;
    step(15);

    // Simultaneous Down and Right: Down wins, Right only after Down release.
    n = cyc;
    push(n + 7, 1); push(n + 16, 3);
    down = 1'b1;
    right = 1'b1;
    step(8);
    down = 1'b0;
    step(8);
    right = 1'b0;
    step(15);

    // Move disabled while Up held, then enabled for a short window.
    tb_if.move_en = 1'b0;
    n = cyc;
    up = 1'b1;
    step(12);
    push(n + 13, 0);
    tb_if.move_en = 1'b1;
    step(3);
    tb_if.move_en = 1'b0;
    up = 1'b0;
    step(15);
    tb_if.move_en = 1'b1;
    step(5);

    // Reset lands on a pulse cycle; held button is a fresh press afterwards.
    n = cyc;
    push(n + 7, 0); push(n + 17, 0); push(n + 22, 0);
    up = 1'b1;
    step(22);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", int'({o_start, tb_if.mvt}), 0);
    step(3);
    n = cyc;
    push(n + 7, 0);
    rst_n = 1'b1;
    step(9);
    up = 1'b0;
    step(15);

    // Two start presses, with moves disabled to show independence.
    tb_if.move_en = 1'b0;
    n = cyc;
    push(n + 7, ID_START); push(n + 19, ID_START);
    start = 1'b1;
    step(6);
    start = 1'b0;
    step(6);
    start = 1'b1;
    step(6);
    start = 1'b0;
    step(15);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
